// File: rtl/jk_bank_driver.sv
// jk_bank_driver: stimulus-and-check engine for a bank of WIDTH external JK
// flip-flops sharing clk. A target word is accepted over valid/ready. The J/K
// excitation is derived from the bank's current q and driven for one cycle.
// One cycle later the bank is compared against the target.
// Optional build macro: JK_TOGGLE_EN -- changed bits use toggle (J=K=1)
// excitation instead of set/reset. Unchanged bits always use hold.
module jk_bank_driver #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic             clr_err,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [WIDTH-1:0] mismatch_bits,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_q_d;
   logic [WIDTH-1:0] exc_j, exc_k;
   logic [WIDTH-1:0] j_d, k_d, bits_d;
   logic             done_d, mis_d;
   logic [7:0]       cnt_d;

   assign tgt_ready = (state == IDLE) && rst;
   assign busy      = (state != IDLE);

   // Excitation from current bank state (c) and requested state (t).
`ifdef JK_TOGGLE_EN
   assign exc_j = q_fb ^ tgt_data;
   assign exc_k = q_fb ^ tgt_data;
`else
   assign exc_j = ~q_fb & tgt_data;
   assign exc_k = q_fb & ~tgt_data;
`endif

   // Next-state and next-output decode for the three-phase transaction.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d = state;
      tgt_q_d = tgt_q;
      j_d     = '0;
      k_d     = '0;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      bits_d  = mismatch_bits;
      cnt_d   = err_cnt;
      case (state)
         IDLE: begin
            if (tgt_valid) begin
               state_d = DRIVE;
               tgt_q_d = tgt_data;
               j_d     = exc_j;
               k_d     = exc_k;
            end
         end
         DRIVE: state_d = CHECK;
         CHECK: begin
            state_d = IDLE;
            done_d  = 1'b1;
            mis_d   = (q_fb != tgt_q);
            bits_d  = q_fb ^ tgt_q;
            if (mis_d && (err_cnt != 8'hFF)) cnt_d = err_cnt + 8'd1;
         end
         default: state_d = IDLE;
      endcase
      // Clear wins over a coincident increment.
      if (clr_err) cnt_d = 8'd0;
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // Registered excitation, check results and error counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tgt_q         <= '0;
         j             <= '0;
         k             <= '0;
         done          <= 1'b0;
         mismatch      <= 1'b0;
         mismatch_bits <= '0;
         err_cnt       <= 8'd0;
      end else begin
         tgt_q         <= tgt_q_d;
         j             <= j_d;
         k             <= k_d;
         done          <= done_d;
         mismatch      <= mis_d;
         mismatch_bits <= bits_d;
         err_cnt       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver: behavioural JK bank with optional
// stuck-at-0 faults, transaction-level reference model, per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_jk_bank_driver;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tgt_valid = 1'b0;
   logic         tgt_ready;
   logic [W-1:0] tgt_data = '0;
   logic [W-1:0] q_fb;
   logic [W-1:0] j, k;
   logic         clr_err = 1'b0;
   logic         busy, done, mismatch;
   logic [W-1:0] mismatch_bits;
   logic [7:0]   err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   jk_bank_driver #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .tgt_data(tgt_data), .q_fb(q_fb), .j(j), .k(k), .clr_err(clr_err),
      .busy(busy), .done(done), .mismatch(mismatch),
      .mismatch_bits(mismatch_bits), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // External JK bank; stuck0 forces selected bits to 0.
   logic [W-1:0] bank   = '0;
   logic [W-1:0] stuck0 = '0;
   assign q_fb = bank;
   always @(posedge clk)
      if (!$isunknown({j, k})) bank <= ((~bank & j) | (bank & ~k)) & ~stuck0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference model.
   int           edge_n = 0;
   int           acc_edge = 0;
   bit           pend = 0;
   bit           was_idle;
   logic [W-1:0] m_tgt = '0, m_j = '0, m_k = '0, m_bits = '0;
   bit           m_done = 0, m_mis = 0;
   int           m_cnt = 0;
   bit           chk_en = 0;

   always @(posedge clk) begin
      if (!rst) begin
         pend = 0; m_j = '0; m_k = '0; m_done = 0; m_mis = 0; m_bits = '0; m_cnt = 0;
      end else begin
         was_idle = !pend;
         m_j = '0; m_k = '0; m_done = 0;
         if (pend && (edge_n - acc_edge == 2)) begin
            m_done = 1;
            m_mis  = (bank != m_tgt);
            m_bits = bank ^ m_tgt;
            if (m_mis && m_cnt < 255) m_cnt++;
            pend = 0;
         end
         if (clr_err) m_cnt = 0;
         if (was_idle && tgt_valid) begin
            pend = 1; acc_edge = edge_n; m_tgt = tgt_data;
            for (int b = 0; b < W; b++) begin
               if (bank[b] != tgt_data[b]) begin
`ifdef JK_TOGGLE_EN
                  m_j[b] = 1'b1; m_k[b] = 1'b1;
`else
                  if (tgt_data[b]) m_j[b] = 1'b1;
                  else             m_k[b] = 1'b1;
`endif
               end
            end
         end
      end
      edge_n++;
   end

   // Per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("tgt_ready", tgt_ready, !pend && rst);
         check("busy", busy, pend);
         check("j", j, m_j);
         check("k", k, m_k);
         check("done", done, m_done);
         if (m_done) check("mismatch", mismatch, m_mis);
         check("mismatch_bits", mismatch_bits, m_bits);
         check("err_cnt", err_cnt, m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !tgt_ready; i++) step();
      check("ready_wait", tgt_ready, 1);
   endtask

   // One accept; returns the DRIVE-cycle excitation, ends in the done cycle.
   task automatic txn(input logic [W-1:0] t, input logic clr,
                      output logic [W-1:0] oj, output logic [W-1:0] ok);
      wait_ready();
      tgt_valid = 1'b1; tgt_data = t;
      step();
      tgt_valid = 1'b0; oj = j; ok = k;
      step();
      clr_err = clr;
      step();
      clr_err = 1'b0;
   endtask

   logic [W-1:0] sj, sk;
   int           dn, jk_seen;

   initial begin
      // Reset with valid asserted.
      rst = 1'b0; tgt_valid = 1'b1; tgt_data = 4'b1111;
      step(); step();
      check("rst_ready", tgt_ready, 0);
      check("rst_j", j, 0);
      check("rst_k", k, 0);
      check("rst_err", err_cnt, 0);
      check("rst_done", done, 0);
      chk_en = 1;
      tgt_valid = 1'b0; rst = 1'b1;
      #1 check("rel_ready", tgt_ready, 1);

      // Set bits from 0000.
      txn(4'b1010, 1'b0, sj, sk);
      check("set_j", sj, 4'b1010);
      check("set_k", sk, 4'b0000);
      check("set_done", done, 1);
      check("set_mis", mismatch, 0);
      check("set_bank", bank, 4'b1010);

      // Mixed set/reset: bank 1100 -> 1010.
      txn(4'b1100, 1'b0, sj, sk);
      check("mix_pre_bank", bank, 4'b1100);
      txn(4'b1010, 1'b0, sj, sk);
`ifdef JK_TOGGLE_EN
      check("mix_j", sj, 4'b0110);
      check("mix_k", sk, 4'b0110);
`else
      check("mix_j", sj, 4'b0010);
      check("mix_k", sk, 4'b0100);
`endif
      check("mix_mis", mismatch, 0);
      check("mix_bank", bank, 4'b1010);

      // Faulty bank: bit0 stuck at 0.
      stuck0 = 4'b0001;
      txn(4'b0001, 1'b0, sj, sk);
      check("flt_mis", mismatch, 1);
      check("flt_bits", mismatch_bits, 4'b0001);
      check("flt_err", err_cnt, 1);
      for (int i = 1; i < 300; i++) txn(4'b0001, 1'b0, sj, sk);
      check("flt_sat", err_cnt, 255);
      txn(4'b0001, 1'b1, sj, sk);
      check("clr_mis", mismatch, 1);
      check("clr_err", err_cnt, 0);
      stuck0 = '0;

      // Back-to-back with target equal to the bank.
      tgt_valid = 1'b1; tgt_data = 4'b0000;
      dn = 0; jk_seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done) dn++;
         if ((j | k) != 0) jk_seen++;
      end
      tgt_valid = 1'b0;
      check("b2b_dones", dn, 5);
      check("b2b_jk", jk_seen, 0);

      // Abort during DRIVE.
      tgt_valid = 1'b1; tgt_data = 4'b0110;
      step();
      tgt_valid = 1'b0; rst = 1'b0;
      step();
      check("abt_j", j, 0);
      check("abt_k", k, 0);
      check("abt_done", done, 0);
      check("abt_busy", busy, 0);
      rst = 1'b1;
      step();
      check("abt_ready", tgt_ready, 1);
      check("abt_err", err_cnt, 0);
      step();
      check("abt_done2", done, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 900; i++) begin
         tgt_valid = 1'($urandom_range(0, 1));
         tgt_data  = W'($urandom);
         clr_err   = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 63) != 0);
         if (i % 50 == 0) stuck0 = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
         step();
      end
      tgt_valid = 1'b0; clr_err = 1'b0; rst = 1'b1;
      step(); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
